// File: rtl/qspi_psram_ctrl.sv
// qspi_psram_ctrl: host-side QSPI PSRAM controller (0xEB read, 0x38 write, 0x66/0x99 reset).
// Revision: 1.0
`default_nettype none

module qspi_psram_ctrl #(
    parameter int CLK_DIV = 4,
    parameter int RD_WAIT = 6,
    parameter int CE_HI   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [23:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_ack,
    output logic [31:0] o_rdata,
    output logic        o_busy,
    output logic        o_init_done,
    output logic        o_sck,
    output logic        o_ce_n,
    output logic [3:0]  o_sio_out,
    output logic        o_sio_oe,
    input  logic [3:0]  i_sio_in
);

    localparam logic [3:0] c_DIV_MAX = 4'(CLK_DIV - 1);
    localparam logic [3:0] c_RDW_MAX = 4'(RD_WAIT - 1);
    localparam logic [3:0] c_CEH_MAX = 4'(2 * CE_HI - 1);

    typedef enum logic [3:0] {
        S_RST_EN, S_RST, S_IDLE, S_CMD, S_ADR, S_WAIT, S_WDAT, S_RDAT, S_DESEL
    } state_t;

    // Byte swap maps between the little-endian word and the nibble stream order.
    function automatic logic [31:0] swap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    state_t      r_state;
    logic [3:0]  r_div;
    logic [3:0]  r_cnt;
    logic [31:0] r_sh;
    logic        r_end;
    logic [1:0]  r_init_step;
    logic        r_we;
    logic [21:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_ack;
    logic [31:0] r_rdata;
    logic        r_busy;
    logic        r_init_done;
    logic        r_sck;
    logic        r_ce_n;
    logic [3:0]  r_sio;
    logic        r_sio_oe;

    logic        w_tick;
    logic        w_desel_done;
    logic        w_start;
    logic [7:0]  w_cmd;
    logic [31:0] w_wswap;
    logic        w_unused_ok;

    assign w_tick       = (r_div == c_DIV_MAX);
    assign w_desel_done = (r_state == S_DESEL) && w_tick && (r_cnt == c_CEH_MAX);
    assign w_start      = ((r_state == S_IDLE) && i_req) ||
                          (w_desel_done && !r_init_done && (r_init_step != 2'd2));
    assign w_cmd        = (r_state == S_IDLE) ? (i_we ? 8'h38 : 8'hEB) :
                          ((r_init_step == 2'd0) ? 8'h66 : 8'h99);
    assign w_wswap      = swap32(r_wdata);
    assign w_unused_ok  = &{1'b0, i_addr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            // Counters preloaded so the 0x66 frame starts on the first clk after reset.
            r_state     <= S_DESEL;
            r_div       <= c_DIV_MAX;
            r_cnt       <= c_CEH_MAX;
            r_sh        <= '0;
            r_end       <= 1'b0;
            r_init_step <= 2'd0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_ack       <= 1'b0;
            r_rdata     <= '0;
            r_busy      <= 1'b1;
            r_init_done <= 1'b0;
            r_sck       <= 1'b0;
            r_ce_n      <= 1'b1;
            r_sio       <= '0;
            r_sio_oe    <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            if (w_start) begin
                r_ce_n   <= 1'b0;
                r_div    <= '0;
                r_cnt    <= '0;
                r_end    <= 1'b0;
                r_sck    <= 1'b0;
                r_sio_oe <= 1'b1;
                r_sh     <= {w_cmd, 24'h0};
                r_sio    <= {3'b000, w_cmd[7]};
                r_busy   <= 1'b1;
                if (r_state == S_IDLE) begin
                    r_state <= S_CMD;
                    r_we    <= i_we;
                    r_addr  <= i_addr[23:2];
                    r_wdata <= i_wdata;
                end else begin
                    r_state     <= (r_init_step == 2'd0) ? S_RST_EN : S_RST;
                    r_init_step <= r_init_step + 2'd1;
                end
            end else if (r_state == S_DESEL) begin
                if (!w_tick) begin
                    r_div <= r_div + 4'd1;
                end else begin
                    r_div <= '0;
                    if (r_cnt == c_CEH_MAX) begin
                        r_cnt       <= '0;
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                        r_init_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
            end else if (!r_ce_n) begin
                if (!w_tick) begin
                    r_div <= r_div + 4'd1;
                end else begin
                    r_div <= '0;
                    if (r_end) begin
                        // Tail: the slot of the next sck rise closes the frame instead.
                        r_ce_n   <= 1'b1;
                        r_sio_oe <= 1'b0;
                        r_sio    <= '0;
                        r_cnt    <= '0;
                        r_state  <= S_DESEL;
                        r_ack    <= r_init_done;
                        if (r_init_done && !r_we) begin
                            r_rdata <= swap32(r_sh);
                        end
                    end else if (!r_sck) begin
                        r_sck <= 1'b1;
                        if (r_state == S_RDAT) begin
                            r_sh <= {r_sh[27:0], i_sio_in};
                        end
                    end else begin
                        r_sck <= 1'b0;
                        case (r_state)
                            S_RST_EN, S_RST, S_CMD: begin
                                if (r_cnt != 4'd7) begin
                                    r_cnt <= r_cnt + 4'd1;
                                    r_sh  <= {r_sh[30:0], 1'b0};
                                    r_sio <= {3'b000, r_sh[30]};
                                end else if (r_state == S_CMD) begin
                                    r_state <= S_ADR;
                                    r_cnt   <= '0;
                                    r_sh    <= {r_addr, 2'b00, 8'h00};
                                    r_sio   <= r_addr[21:18];
                                end else begin
                                    r_end <= 1'b1;
                                end
                            end
                            S_ADR: begin
                                if (r_cnt != 4'd5) begin
                                    r_cnt <= r_cnt + 4'd1;
                                    r_sh  <= {r_sh[27:0], 4'h0};
                                    r_sio <= r_sh[27:24];
                                end else if (r_we) begin
                                    r_state <= S_WDAT;
                                    r_cnt   <= '0;
                                    r_sh    <= w_wswap;
                                    r_sio   <= w_wswap[31:28];
                                end else begin
                                    r_state  <= (RD_WAIT == 0) ? S_RDAT : S_WAIT;
                                    r_cnt    <= '0;
                                    r_sio_oe <= 1'b0;
                                    r_sio    <= '0;
                                end
                            end
                            S_WAIT: begin
                                if (r_cnt == c_RDW_MAX) begin
                                    r_state <= S_RDAT;
                                    r_cnt   <= '0;
                                end else begin
                                    r_cnt <= r_cnt + 4'd1;
                                end
                            end
                            S_WDAT: begin
                                if (r_cnt != 4'd7) begin
                                    r_cnt <= r_cnt + 4'd1;
                                    r_sh  <= {r_sh[27:0], 4'h0};
                                    r_sio <= r_sh[27:24];
                                end else begin
                                    r_end <= 1'b1;
                                end
                            end
                            S_RDAT: begin
                                if (r_cnt != 4'd7) begin
                                    r_cnt <= r_cnt + 4'd1;
                                end else begin
                                    r_end <= 1'b1;
                                end
                            end
                            default: r_state <= S_DESEL;
                        endcase
                    end
                end
            end
        end
    end

    assign o_ack       = r_ack;
    assign o_rdata     = r_rdata;
    assign o_busy      = r_busy;
    assign o_init_done = r_init_done;
    assign o_sck       = r_sck;
    assign o_ce_n      = r_ce_n;
    assign o_sio_out   = r_sio;
    assign o_sio_oe    = r_sio_oe;

endmodule

`default_nettype wire
